multicycle_control: RTL

Parametrised multi-cycle control unit for the next-generation processor datapath. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that walks each instruction through fetch, decode, execute, memory and write-back, and waits on instruction/data memory ready handshakes. A wait-state timeout turns stalled memory requests into a trap, and illegal opcodes trap instead of silently decoding as no-ops. It sits between the instruction register opcode field and the datapath muxes, register file and memory ports.

---
 rtl/multicycle_control.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back with ready handshakes.
// 3-5 cycles per instruction plus one per memory wait cycle; stalled requests trap after MEM_TIMEOUT cycles.
module multicycle_control #(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                sign_or_zero,
  output logic                instr_done,
  output logic                trap,
  output logic                trap_cause,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cause_q, cause_d;
  logic [2:0]       op3;
  logic             op_legal;
  logic             timeout_hit;
  logic             zero_unused;

  // The datapath gates the conditional PC load with zero itself.
  assign zero_unused = zero;
  assign op3         = opcode[2:0];
  assign op_legal    = ((opcode >> 3) == '0);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    cause_d       = cause_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    sign_or_zero  = 1'b1;
    instr_done    = 1'b0;
    trap          = 1'b0;
    trap_cause    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = imem_ready;
        pc_write  = imem_ready;
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        if (!op_legal) begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end else begin
          unique case (op3)
            3'b000, 3'b001: state_d = S_EXEC_R;
            3'b111:         state_d = S_EXEC_I;
            3'b100, 3'b101: state_d = S_ADDR;
            3'b110:         state_d = S_BRANCH;
            default:        state_d = S_JUMP;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = (op3 == 3'b001) ? 2'b11 : 2'b10;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst    = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op3 == 3'b101) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = (state_q == S_MEM_WR);
        if (dmem_ready) begin
          instr_done = (state_q == S_MEM_WR);
          state_d    = (state_q == S_MEM_WR) ? S_FETCH : S_WB_MEM;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB_MEM: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        // jal links the already-incremented PC into r31.
        if (op3 == 3'b011) begin
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          reg_write  = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
